seq_divider_8by4: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_8by4_div_step_stage.sv | 24 ++
 rtl/seq_divider_8by4.sv | 108 ++++++++++
 tb/tb_seq_divider_8by4.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;
  localparam int COUNT_W        = $clog2(DIVIDEND_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/seq_divider_8by4_div_step_stage.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
// Purely combinational; no handshake.
module div_step_stage
  import seq_divider_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;

  // The difference is always below the divisor, so the low DIVISOR_W+1 bits hold it exactly.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? (shifted[DIVISOR_W:0] - {1'b0, divisor}) : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/seq_divider_8by4.sv
// Restoring divider, one quotient bit per clk: done at E9, or E1 for divide-by-zero / small dividend (SEQ_DIVIDER_EARLY_EXIT_EN).
// start is honoured only while ready=1; requests while busy are dropped, not queued.
module seq_divider_8by4
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  ready,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  div_state_t            state;
  logic [CNT_W-1:0]      count;
  logic [DIVIDEND_W-1:0] work;
  logic [DIVISOR_W-1:0]  dvsr;
  logic [DIVISOR_W:0]    prem;
  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step_stage #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .rem_in (prem),
    .bit_in (work[DIVIDEND_W-1]),
    .divisor(dvsr),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      work        <= '0;
      dvsr        <= '0;
      prem        <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work        <= dividend;
            dvsr        <= divisor;
            prem        <= '0;
            count       <= '0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
              state       <= DONE;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
            end else if (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor}) begin
              quotient  <= '0;
              remainder <= dividend[DIVISOR_W-1:0];
              state     <= DONE;
`endif
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // Quotient bits enter at the LSB as dividend bits leave the MSB.
          work  <= {work[DIVIDEND_W-2:0], step_q};
          prem  <= step_rem;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(DIVIDEND_W - 1)) begin
            quotient  <= {work[DIVIDEND_W-2:0], step_q};
            remainder <= step_rem[DIVISOR_W-1:0];
            state     <= DONE;
          end
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Self-checking bench for seq_divider_8by4: directed vector table, busy/reset corners, random ops vs arithmetic model.
module tb_seq_divider_8by4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider_8by4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [7:0] a, input logic [3:0] b);
    if (b == 4'd0) return 1;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    if (int'(a) < int'(b)) return 1;
`endif
    return 9;
  endfunction

  // Issues one op from IDLE; optionally pokes a second start at edge poke_at.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int poke_at,
                        output logic [7:0] q, output logic [3:0] r, output logic dbz,
                        output int lat, output int ready_bad, output int tail_bad);
    lat = 0; ready_bad = 0; tail_bad = 0;
    q = '0; r = '0; dbz = 1'b0;
    dividend = a; divisor = b; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    dividend = 8'($urandom); divisor = 4'($urandom);
    for (int n = 1; n <= 30; n++) begin
      if (n == poke_at) begin
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
      end
      tick();
      start = 1'b0;
      if (ready !== 1'b0) ready_bad++;
      if (done === 1'b1) begin
        lat = n; q = quotient; r = remainder; dbz = div_by_zero;
        break;
      end
    end
    tick();
    if (done !== 1'b0 || ready !== 1'b1) tail_bad++;
  endtask

  task automatic apply(input string nm, input vec_t v, input int poke_at);
    logic [7:0] q; logic [3:0] r; logic dbz;
    int lat, rb, tb;
    run_op(v.a, v.b, poke_at, q, r, dbz, lat, rb, tb);
    check({nm, ".quotient"}, int'(q), int'(v.q));
    check({nm, ".remainder"}, int'(r), int'(v.r));
    check({nm, ".div_by_zero"}, int'(dbz), int'(v.dbz));
    check({nm, ".latency"}, lat, v.lat);
    check({nm, ".busy_ready"}, rb, 0);
    check({nm, ".done_one_cycle"}, tb, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int pulses;
    vec_t v;
    logic [7:0] qh;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    check("reset.ready", int'(ready), 1);
    check("reset.done", int'(done), 0);
    check("reset.quotient", int'(quotient), 0);
    check("reset.remainder", int'(remainder), 0);
    check("reset.div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;
    tick();

    vecs.push_back('{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 9});
    vecs.push_back('{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 9});
    vecs.push_back('{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 9});
    vecs.push_back('{8'd13,  4'd0,  8'hFF,  4'd13, 1'b1, 1});
    vecs.push_back('{8'd9,   4'd3,  8'd3,   4'd0,  1'b0, 9});
    vecs.push_back('{8'd5,   4'd9,  8'd0,   4'd5,  1'b0, model_lat(8'd5, 4'd9)});
    vecs.push_back('{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, model_lat(8'd0, 4'd5)});
    vecs.push_back('{8'd77,  4'd6,  8'd12,  4'd5,  1'b0, 9});
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i], 0);

    // Results hold after done while idle.
    qh = quotient;
    tick(); tick(); tick();
    check("hold.quotient", int'(quotient), 12);
    check("hold.quotient_stable", int'(quotient), int'(qh));
    check("hold.remainder", int'(remainder), 5);

    // Start while busy is dropped and not queued.
    apply("busy_poke", '{8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9}, 4);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("busy_poke.no_requeue", pulses, 0);

    // Reset mid-run aborts with no done pulse.
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midreset.ready", int'(ready), 1);
    check("midreset.done", int'(done), 0);
    check("midreset.quotient", int'(quotient), 0);
    check("midreset.remainder", int'(remainder), 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("midreset.no_done", pulses, 0);
    apply("after_reset", '{8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 9}, 0);

    // Random ops against plain-arithmetic expectations.
    for (int k = 0; k < 60; k++) begin
      v.a = 8'($urandom);
      v.b = (k % 10 == 0) ? 4'd0 : 4'($urandom);
      if (v.b == 4'd0) begin
        v.q = 8'hFF; v.r = v.a[3:0]; v.dbz = 1'b1;
      end else begin
        v.q = 8'(int'(v.a) / int'(v.b));
        v.r = 4'(int'(v.a) % int'(v.b));
        v.dbz = 1'b0;
      end
      v.lat = model_lat(v.a, v.b);
      apply($sformatf("rand%0d_%0d/%0d", k, v.a, v.b), v, 0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
